// File: rtl/pw_digit_store_if.sv
// Keypad-side and status signals of the password digit store, bundled so the
// store and its driver share one definition of widths and directions.
interface pw_digit_store_if #(
  parameter int DIGITS    = 4,
  parameter int DIGIT_W   = 4,
  parameter int MAX_TRIES = 3
) ();
  logic [DIGIT_W-1:0]             hex_in;
  logic                           is_guessing_pw;
  logic                           enter;
  logic                           clear;
  logic [DIGITS*DIGIT_W-1:0]      guess_pw;
  logic [DIGITS*DIGIT_W-1:0]      actual_pw;
  logic                           pw_set;
  logic                           match;
  logic                           fail;
  logic                           locked;
  logic [$clog2(MAX_TRIES+1)-1:0] tries;

  modport master (
    output hex_in, is_guessing_pw, enter, clear,
    input  guess_pw, actual_pw, pw_set, match, fail, locked, tries
  );

  modport slave (
    input  hex_in, is_guessing_pw, enter, clear,
    output guess_pw, actual_pw, pw_set, match, fail, locked, tries
  );
endinterface

// File: rtl/pw_digit_store.sv
// Keypad digit store: collects a password and guesses digit by digit, compares
// completed guesses, and locks the keypad after too many consecutive failures.
module pw_digit_store #(
  parameter int DIGITS      = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 8
) (
  input  logic            clk,
  input  logic            reset,
  pw_digit_store_if.slave bus
);
  localparam int BUF_W = DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);
  localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCK_CYCLES);

  logic [BUF_W-1:0] guess_q, guess_d, actual_q, actual_d;
  logic [CNT_W-1:0] g_cnt_q, g_cnt_d, p_cnt_q, p_cnt_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [TMR_W-1:0] lock_tmr_q, lock_tmr_d;
  logic             pw_set_q, pw_set_d, match_q, match_d, fail_q, fail_d;
  logic             locked_q, locked_d, enter_q, mode_q, armed_q, armed_d;

  logic guess_mode, key_press, mode_chg, cmp_pend, accept;

  assign guess_mode = bus.is_guessing_pw;
  // armed_q keeps an enter held across reset release from counting as a press.
  assign key_press  = bus.enter & ~enter_q & armed_q;
  assign mode_chg   = guess_mode != mode_q;
  assign cmp_pend   = g_cnt_q == CNT_FULL;
  assign accept     = key_press & ~bus.clear & ~mode_chg & ~locked_q & ~cmp_pend
                      & (~guess_mode | pw_set_q);

  // NOTE: every always_comb target gets a default first, so no latch is inferred.
  always_comb begin
    guess_d    = guess_q;
    actual_d   = actual_q;
    g_cnt_d    = g_cnt_q;
    p_cnt_d    = p_cnt_q;
    pw_set_d   = pw_set_q;
    tries_d    = tries_q;
    lock_tmr_d = lock_tmr_q;
    locked_d   = locked_q;
    match_d    = 1'b0;
    fail_d     = 1'b0;
    armed_d    = armed_q | ~bus.enter;

    if (cmp_pend) begin
      g_cnt_d = '0;
      if (guess_q == actual_q) begin
        match_d = 1'b1;
        tries_d = '0;
      end else begin
        fail_d = 1'b1;
        if (tries_q != TRY_MAX) tries_d = tries_q + 1'b1;
      end
    end

    if (accept && guess_mode) begin
      guess_d = (guess_q << DIGIT_W) | BUF_W'(bus.hex_in);
      g_cnt_d = g_cnt_q + 1'b1;
    end
    if ((guess_mode && bus.clear) || mode_chg) g_cnt_d = '0;

    if (accept && !guess_mode) begin
      actual_d = (actual_q << DIGIT_W) | BUF_W'(bus.hex_in);
      p_cnt_d  = (p_cnt_q == CNT_FULL) ? CNT_W'(1) : p_cnt_q + 1'b1;
      pw_set_d = 1'b0;
    end else if (p_cnt_q == CNT_FULL) begin
      pw_set_d = 1'b1;
    end
    if (!guess_mode && bus.clear) p_cnt_d = '0;
    // A started but unfinished password entry is abandoned on a mode switch.
    if (mode_chg && p_cnt_q != '0 && p_cnt_q != CNT_FULL) begin
      p_cnt_d  = '0;
      pw_set_d = 1'b0;
    end

    if (locked_q) begin
      if (lock_tmr_q == TMR_W'(1)) begin
        locked_d   = 1'b0;
        lock_tmr_d = '0;
        tries_d    = '0;
      end else begin
        lock_tmr_d = lock_tmr_q - 1'b1;
      end
    end else if (fail_q && tries_q == TRY_MAX) begin
      locked_d   = 1'b1;
      lock_tmr_d = TMR_LOAD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      guess_q    <= '0;
      actual_q   <= '0;
      g_cnt_q    <= '0;
      p_cnt_q    <= '0;
      pw_set_q   <= 1'b0;
      match_q    <= 1'b0;
      fail_q     <= 1'b0;
      locked_q   <= 1'b0;
      tries_q    <= '0;
      lock_tmr_q <= '0;
      enter_q    <= 1'b0;
      mode_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      guess_q    <= guess_d;
      actual_q   <= actual_d;
      g_cnt_q    <= g_cnt_d;
      p_cnt_q    <= p_cnt_d;
      pw_set_q   <= pw_set_d;
      match_q    <= match_d;
      fail_q     <= fail_d;
      locked_q   <= locked_d;
      tries_q    <= tries_d;
      lock_tmr_q <= lock_tmr_d;
      enter_q    <= bus.enter;
      mode_q     <= guess_mode;
      armed_q    <= armed_d;
    end
  end

  assign bus.guess_pw  = guess_q;
  assign bus.actual_pw = actual_q;
  assign bus.pw_set    = pw_set_q;
  assign bus.match     = match_q;
  assign bus.fail      = fail_q;
  assign bus.locked    = locked_q;
  assign bus.tries     = tries_q;
endmodule

// File: tb/tb_pw_digit_store.sv
// Self-checking bench for pw_digit_store: expected compare results are queued
// when a guess is keyed in and popped when match/fail pulses appear.
module tb_pw_digit_store;
  logic clk = 1'b0;
  logic reset;

  pw_digit_store_if #(.DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3)) bus ();

  pw_digit_store #(.DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3), .LOCK_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   exp_q[$];
  logic [15:0] m_actual = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d, input int hold = 1);
    bus.hex_in = d;
    bus.enter  = 1'b1;
    repeat (hold) tick();
    bus.enter  = 1'b0;
    tick();
  endtask

  task automatic set_mode(input logic m);
    bus.is_guessing_pw = m;
    tick();
  endtask

  task automatic enter_pw(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) press(code[i*4 +: 4]);
    m_actual = code;
  endtask

  task automatic enter_guess(input logic [15:0] code, input bit expect_result);
    if (expect_result) exp_q.push_back(code == m_actual);
    for (int i = 3; i >= 0; i--) press(code[i*4 +: 4]);
  endtask

  task automatic wait_results();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check("results_drained", exp_q.size(), 0);
  endtask

  // Scoreboard consumer: every match/fail pulse must correspond to a queued guess.
  always @(negedge clk) begin
    if (!reset && (bus.match || bus.fail)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {30'b0, bus.match, bus.fail}, 0);
      end else begin
        automatic bit e = exp_q.pop_front();
        check("result", {30'b0, bus.match, bus.fail}, e ? 32'h2 : 32'h1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc;
    reset = 1'b1;
    bus.enter = 1'b1;
    bus.hex_in = 4'h5;
    bus.is_guessing_pw = 1'b0;
    bus.clear = 1'b0;
    repeat (3) tick();
    check("rst_guess_pw", bus.guess_pw, 0);
    check("rst_actual_pw", bus.actual_pw, 0);
    check("rst_pw_set", bus.pw_set, 0);
    check("rst_match", bus.match, 0);
    check("rst_fail", bus.fail, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_tries", bus.tries, 0);

    // Enter held through reset release must not register a digit.
    reset = 1'b0;
    repeat (3) tick();
    check("no_press_across_reset", bus.actual_pw, 0);
    bus.enter = 1'b0;
    tick();

    // Password entry, first key held for 10 cycles.
    press(4'h1, 10);
    check("held_enter_one_digit", bus.actual_pw, 16'h0001);
    press(4'h2);
    press(4'h3);
    check("pw_set_partial", bus.pw_set, 0);
    press(4'h4);
    m_actual = 16'h1234;
    tick();
    check("actual_pw_1234", bus.actual_pw, 16'h1234);
    check("pw_set_full", bus.pw_set, 1);

    // Correct guess.
    set_mode(1'b1);
    enter_guess(16'h1234, 1);
    wait_results();
    check("guess_pw_1234", bus.guess_pw, 16'h1234);
    check("tries_after_match", bus.tries, 0);

    // A failure followed by a match clears the try count.
    enter_guess(16'hFFFF, 1);
    wait_results();
    check("tries_one_fail", bus.tries, 1);
    enter_guess(16'h1234, 1);
    wait_results();
    check("tries_cleared_by_match", bus.tries, 0);

    // Three failures trigger lockout.
    for (int k = 0; k < 3; k++) begin
      enter_guess(16'hFFFF, 1);
      if (k < 2) begin
        wait_results();
        check("tries_count", bus.tries, k + 1);
      end
    end
    check("tries_at_max", bus.tries, 3);
    check("locked_not_yet", bus.locked, 0);
    lc = 0;
    for (int i = 0; i < 20; i++) begin
      bus.hex_in = 4'h7;
      bus.enter  = (i < 8) ? i[0] : 1'b0;
      tick();
      if (bus.locked) lc++;
    end
    check("lock_duration", lc, 8);
    check("tries_after_lock", bus.tries, 0);
    check("keys_ignored_when_locked", bus.guess_pw, 16'hFFFF);
    check("results_after_lock", exp_q.size(), 0);

    // Partial guess discarded by clear.
    press(4'hA);
    press(4'hA);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    tick();
    enter_guess(16'h1234, 1);
    wait_results();
    check("guess_after_clear", bus.guess_pw, 16'h1234);

    // Re-entering the password restarts the entry.
    set_mode(1'b0);
    press(4'h5);
    check("pw_set_restart", bus.pw_set, 0);
    check("actual_shift", bus.actual_pw, 16'h2345);
    press(4'h6);
    press(4'h7);
    press(4'h8);
    m_actual = 16'h5678;
    tick();
    check("actual_pw_5678", bus.actual_pw, 16'h5678);
    check("pw_set_again", bus.pw_set, 1);
    set_mode(1'b1);
    enter_guess(16'h5678, 1);
    wait_results();

    // A started password entry abandoned by a mode switch clears pw_set.
    set_mode(1'b0);
    press(4'h9);
    set_mode(1'b1);
    check("pw_set_abandoned", bus.pw_set, 0);
    enter_guess(16'h1111, 0);
    repeat (3) tick();
    check("guess_ignored_unset", bus.guess_pw, 16'h5678);

    // After reset with no password, guesses are ignored.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_actual = '0;
    tick();
    enter_guess(16'h4321, 0);
    repeat (3) tick();
    check("guess_ignored_after_rst", bus.guess_pw, 0);

    // Reset during lockout.
    set_mode(1'b0);
    enter_pw(16'h1234);
    tick();
    set_mode(1'b1);
    for (int k = 0; k < 3; k++) enter_guess(16'hFFFF, 1);
    repeat (3) tick();
    check("locked_before_rst", bus.locked, 1);
    check("results_before_rst", exp_q.size(), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_lock_locked", bus.locked, 0);
    check("rst_lock_tries", bus.tries, 0);
    check("rst_lock_actual", bus.actual_pw, 0);
    check("rst_lock_pw_set", bus.pw_set, 0);
    repeat (2) tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
